flap_input_ctrl: RTL and testbench

FLAP_INPUT_CTRL -- requirements
Module: flap_input_ctrl

---
 rtl/flap_input_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_flap_input_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flap_input_ctrl.sv
// -----------------------------------------------------------------------------
// flap_input_ctrl
//
// Pushbutton front end for the flap game. Each raw active-low key is
// synchronized, inverted and debounced. Every debounced press is latched as a
// pending event, and one event at a time is offered to the game FSM through a
// valid/ready handshake with round-robin arbitration between keys. A press
// that arrives while the same key still has an event waiting is recorded in
// a sticky per-key dropped flag.
//
// Parameters
//   N_KEYS          number of pushbuttons (2..8)
//   DEBOUNCE_CYCLES consecutive differing cycles before a level flips (>= 2)
//
// Ports
//   clk        clock; all state updates on its rising edge
//   reset      asynchronous, active-high reset
//   key_n      raw asynchronous pushbuttons, 0 = pressed
//   pressed    debounced active-high key levels
//   evt_valid  a key-press event is being offered
//   evt_id     index of the offered key
//   evt_ready  consumer accepts the offered event this cycle
//   dropped    sticky per-key flag: a press on that key was lost
// -----------------------------------------------------------------------------
module flap_input_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_KEYS-1:0]         key_n,
  output logic [N_KEYS-1:0]         pressed,
  output logic                      evt_valid,
  output logic [$clog2(N_KEYS)-1:0] evt_id,
  input  logic                      evt_ready,
  output logic [N_KEYS-1:0]         dropped
);

  localparam int IW = $clog2(N_KEYS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Reset value 1 means "button released".
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync_meta;
  logic [N_KEYS-1:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, exactly like the hardware does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= key_n;
      sync_q    <= sync_meta;
    end
  end

  logic [N_KEYS-1:0] key_level;
  assign key_level = ~sync_q;

  // ---------------------------------------------------------------------------
  // Debounce: a counter per key runs while the synchronized level disagrees
  // with the debounced level and clears as soon as they agree again. After
  // DEBOUNCE_CYCLES consecutive disagreeing samples the level flips.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt [N_KEYS];

  // NOTE: the counter array is ordinary per-key state, not a RAM, so every
  // entry is reset; a stale count would otherwise shorten the first debounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_level[i] == pressed[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]     <= '0;
          pressed[i] <= ~pressed[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rising-edge detect on the debounced level; releases make no event.
  logic [N_KEYS-1:0] pressed_d;
  logic [N_KEYS-1:0] rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pressed_d <= '0;
    else       pressed_d <= pressed;
  end

  assign rise = pressed & ~pressed_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first pending key found searching upward from
  // last_grant+1, wrapping around.
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] pending;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_found;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_idx   = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N_KEYS; k++) begin
      idx = (int'(last_grant) + k) % N_KEYS;
      if (!grant_found && pending[IW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM. A grant moves the chosen key from pending onto evt_id. In
  // OFFER a grant only happens on the accepting cycle, which gives
  // back-to-back events while anything is still pending.
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic              grant_en;
  logic [N_KEYS-1:0] grant_vec;

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        // evt_ready is deliberately not looked at here.
        if (grant_found) begin
          grant_en  = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (grant_found) grant_en  = 1'b1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_vec = grant_en ? (N_KEYS'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      evt_id     <= '0;
      last_grant <= IW'(N_KEYS - 1);  // key 0 wins the first arbitration
      pending    <= '0;
      dropped    <= '0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        evt_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      // A new press always leaves its key pending, even when the old event of
      // the same key is granted on this edge.
      pending <= (pending & ~grant_vec) | rise;
      // A press is lost only if an older one of the same key is still waiting
      // and is not leaving on this edge.
      dropped <= dropped | (rise & pending & ~grant_vec);
    end
  end

  assign evt_valid = (state == OFFER);

endmodule

// File: tb/tb_flap_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flap_input_ctrl
//
// Self-checking bench for flap_input_ctrl with default parameters. Inputs are
// driven 1 time unit after the rising edge; a monitor samples the handshake
// on the falling edge and compares every accepted evt_id against a queue of
// expected key indices filled when the stimulus is applied.
// -----------------------------------------------------------------------------
module tb_flap_input_ctrl;

  localparam int N = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] key_n;
  logic [N-1:0] pressed;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready;
  logic [N-1:0] dropped;

  always #5 clk = ~clk;

  flap_input_ctrl #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .pressed   (pressed),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .dropped   (dropped)
  );

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  typedef struct packed {
    logic [3:0]      key_n;
    logic [7:0]      hold;
    logic [3:0]      exp_pressed;
    logic [2:0]      n_evt;
    logic [3:0][1:0] ids;   // ids[0] is granted first
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected key.
  always @(negedge clk) begin
    if (reset === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // Stable-press vectors, consumer always ready. Order is chosen so the
    // three-key press starts with last grant = 3 (grants 0,2,3) and the
    // following 0+3 press wraps around to key 0 first.
    vecs[0]  = '{key_n: 4'b1101, hold: 8'd5,  exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00}; // short glitch
    vecs[1]  = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};
    vecs[2]  = '{key_n: 4'b1011, hold: 8'd20, exp_pressed: 4'b0100, n_evt: 3'd1, ids: 8'h02};
    vecs[3]  = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};
    vecs[4]  = '{key_n: 4'b0111, hold: 8'd20, exp_pressed: 4'b1000, n_evt: 3'd1, ids: 8'h03};
    vecs[5]  = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};
    vecs[6]  = '{key_n: 4'b0010, hold: 8'd20, exp_pressed: 4'b1101, n_evt: 3'd3, ids: 8'h38}; // 0,2,3
    vecs[7]  = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};
    vecs[8]  = '{key_n: 4'b0110, hold: 8'd20, exp_pressed: 4'b1001, n_evt: 3'd2, ids: 8'h0C}; // 0,3
    vecs[9]  = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};
    vecs[10] = '{key_n: 4'b1101, hold: 8'd20, exp_pressed: 4'b0010, n_evt: 3'd1, ids: 8'h01};
    vecs[11] = '{key_n: 4'b1111, hold: 8'd20, exp_pressed: 4'b0000, n_evt: 3'd0, ids: 8'h00};

    // ---- reset state ----
    reset     = 1'b1;
    key_n     = '1;
    evt_ready = 1'b0;
    tick(3);
    check("rst_pressed",   32'(pressed),   32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_id",    32'(evt_id),    32'h0);
    check("rst_dropped",   32'(dropped),   32'h0);
    reset = 1'b0;
    tick(2);

    // ---- exact latency: pressed at edge D+2, evt_valid at edge D+4 for 1 cycle ----
    evt_ready = 1'b1;
    key_n     = 4'b1110;
    exp_q.push_back(2'd0);
    tick(D + 1);
    check("lat_pressed_early", 32'(pressed),   32'h0);
    tick(1);
    check("lat_pressed_on",    32'(pressed),   32'h1);
    check("lat_valid_early0",  32'(evt_valid), 32'h0);
    tick(1);
    check("lat_valid_early1",  32'(evt_valid), 32'h0);
    tick(1);
    check("lat_valid_on",      32'(evt_valid), 32'h1);
    check("lat_id",            32'(evt_id),    32'h0);
    tick(1);
    check("lat_valid_off",     32'(evt_valid), 32'h0);
    key_n = '1;
    tick(20);
    check("lat_released", 32'(pressed), 32'h0);
    check("lat_drained",  32'(exp_q.size()), 32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      key_n = vecs[i].key_n;
      for (int k = 0; k < int'(vecs[i].n_evt); k++) exp_q.push_back(vecs[i].ids[k]);
      tick(int'(vecs[i].hold));
      check($sformatf("v%0d_pressed", i), 32'(pressed), 32'(vecs[i].exp_pressed));
      check($sformatf("v%0d_dropped", i), 32'(dropped), 32'h0);
      check($sformatf("v%0d_drained", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("v%0d_idle", i),    32'(evt_valid), 32'h0);
    end

    // ---- stalled offer on key 1, two re-presses -> dropped[1] ----
    evt_ready = 1'b0;
    key_n     = 4'b1101;
    exp_q.push_back(2'd1);
    tick(20);
    check("stall_valid", 32'(evt_valid), 32'h1);
    check("stall_id",    32'(evt_id),    32'h1);
    key_n = 4'b1111;
    tick(12);
    check("stall_rel1_id",   32'(evt_id),  32'h1);
    check("stall_rel1_prs",  32'(pressed), 32'h0);
    key_n = 4'b1101;
    tick(12);
    check("stall_prs1_prs",  32'(pressed), 32'h2);
    check("stall_prs1_drop", 32'(dropped), 32'h0);
    check("stall_prs1_id",   32'(evt_id),  32'h1);
    key_n = 4'b1111;
    tick(12);
    key_n = 4'b1101;
    tick(12);
    check("stall_prs2_drop",  32'(dropped),   32'h2);
    check("stall_prs2_id",    32'(evt_id),    32'h1);
    check("stall_prs2_valid", 32'(evt_valid), 32'h1);
    exp_q.push_back(2'd1);
    evt_ready = 1'b1;
    tick(4);
    check("stall_idle",    32'(evt_valid),    32'h0);
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check("stall_sticky",  32'(dropped),      32'h2);
    key_n = 4'b1111;
    tick(20);
    check("stall_sticky2", 32'(dropped), 32'h2);

    // ---- async reset during OFFER drops offered and pending events ----
    evt_ready = 1'b0;
    key_n     = 4'b1011;
    exp_q.push_back(2'd2);
    tick(20);
    check("pre_rst_valid", 32'(evt_valid), 32'h1);
    check("pre_rst_id",    32'(evt_id),    32'h2);
    key_n = 4'b1010;           // key 0 becomes pending behind the offer
    tick(15);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_valid",   32'(evt_valid), 32'h0);
    check("async_rst_dropped", 32'(dropped),   32'h0);
    check("async_rst_pressed", 32'(pressed),   32'h0);
    exp_q.delete();
    key_n     = 4'b1011;       // key 0 let go, key 2 held through reset
    evt_ready = 1'b1;
    tick(3);
    check("rst_hold_valid", 32'(evt_valid), 32'h0);
    reset = 1'b0;
    exp_q.push_back(2'd2);
    tick(D + 3);
    check("post_rst_early", 32'(evt_valid), 32'h0);
    tick(1);
    check("post_rst_valid", 32'(evt_valid), 32'h1);
    check("post_rst_id",    32'(evt_id),    32'h2);
    tick(1);
    check("post_rst_single", 32'(evt_valid), 32'h0);
    tick(20);
    check("post_rst_idle",    32'(evt_valid),    32'h0);
    check("post_rst_pressed", 32'(pressed),      32'h4);
    check("post_rst_dropped", 32'(dropped),      32'h0);
    check("final_drained",    32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
